// File: rtl/add_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead slice per stage,
// one global stall, registered sum/cout/ovf/zero after WIDTH/GROUP cycles.
module add_cla_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    logic adv_s;

    assign adv_s    = !out_valid | out_ready;
    assign in_ready = adv_s;

    // Carry j+1 = g_j | p_j g_(j-1) | ... | p_j..p_0 c_in, each term a flat AND.
    function automatic logic [GROUP:0] cla_carry(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g,
        input logic             c_in
    );
        logic [GROUP:0] c;
        logic           term;
        logic           acc;
        c    = '0;
        c[0] = c_in;
        for (int j = 0; j < GROUP; j++) begin
            term = c_in;
            for (int m = 0; m <= j; m++) begin
                term = term & p[m];
            end
            acc = term;
            for (int k = 0; k <= j; k++) begin
                term = g[k];
                for (int m = k + 1; m <= j; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            c[j+1] = acc;
        end
        return c;
    endfunction

    for (genvar gs = 0; gs < NG; gs++) begin : g_stg
        localparam int LO = gs * GROUP;
        localparam int UW = WIDTH - LO;

        logic [UW-1:0]         a_src_s;
        logic [UW-1:0]         b_src_s;
        logic                  c_src_s;
        logic                  v_src_s;
        logic [GROUP-1:0]      p_s;
        logic [GROUP-1:0]      g_s;
        logic [GROUP:0]        c_s;
        logic [GROUP-1:0]      sl_sum_s;
        logic [LO+GROUP-1:0]   acc_d;
        logic [LO+GROUP-1:0]   acc_q;
        logic                  c_q;
        logic                  v_q;

        if (gs == 0) begin : g_src
            assign a_src_s = a;
            assign b_src_s = sub ? ~b : b;
            assign c_src_s = sub ? 1'b1 : cin;
            assign v_src_s = in_valid;
            assign acc_d   = sl_sum_s;
        end else begin : g_src
            assign a_src_s = g_stg[gs-1].g_op.a_q;
            assign b_src_s = g_stg[gs-1].g_op.b_q;
            assign c_src_s = g_stg[gs-1].c_q;
            assign v_src_s = g_stg[gs-1].v_q;
            assign acc_d   = {sl_sum_s, g_stg[gs-1].acc_q};
        end

        // Slice generate/propagate, lookahead carries and sum bits.
        always_comb begin
            p_s      = a_src_s[GROUP-1:0] ^ b_src_s[GROUP-1:0];
            g_s      = a_src_s[GROUP-1:0] & b_src_s[GROUP-1:0];
            c_s      = cla_carry(p_s, g_s, c_src_s);
            sl_sum_s = p_s ^ c_s[GROUP-1:0];
        end

        // Stage valid, accumulated sum and slice carry-out; data loads even on bubbles.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                acc_q <= '0;
                c_q   <= 1'b0;
            end else if (adv_s) begin
                v_q   <= v_src_s;
                acc_q <= acc_d;
                c_q   <= c_s[GROUP];
            end
        end

        if (gs < NG - 1) begin : g_op
            logic [UW-GROUP-1:0] a_q;
            logic [UW-GROUP-1:0] b_q;

            // Operand bits above this slice travel untouched to later stages.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv_s) begin
                    a_q <= a_src_s[UW-1:GROUP];
                    b_q <= b_src_s[UW-1:GROUP];
                end
            end
        end else begin : g_fin
            logic ovf_d;
            logic zero_d;
            logic ovf_q;
            logic zero_q;

            // Flags are resolved here so every output comes straight from a register.
            always_comb begin
                ovf_d  = (a_src_s[GROUP-1] == b_src_s[GROUP-1]) &
                         (sl_sum_s[GROUP-1] != a_src_s[GROUP-1]);
                zero_d = (acc_d == '0);
            end

            // Output flag registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv_s) begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end

            assign out_valid = v_q;
            assign sum       = acc_q;
            assign cout      = c_q;
            assign ovf       = ovf_q;
            assign zero      = zero_q;
        end
    end

endmodule

// File: doc/add_cla_pipe.md
# add_cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready flow control. Each GROUP-bit slice is a single-level lookahead block (generate/propagate, lookahead carry, sum XOR). A pipeline register sits between consecutive slices, so one operation enters per clock. Results leave after WIDTH/GROUP cycles with carry-out, signed overflow and zero flags. It replaces the fixed 16-bit ripple and 4×4 CLA adders in the datapath wherever throughput matters more than single-cycle latency.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of GROUP.
- GROUP, 4: bits per lookahead slice, range 1..8. NG = WIDTH/GROUP is the number of pipeline stages and the latency.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operands and mode are valid this cycle.
- in_ready  out  1  the pipeline accepts an input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  1: compute a − b (b inverted, carry-in forced to 1, cin ignored). 0: compute a + b + cin.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer takes the result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum equals 0.

## Operation
- Advance condition: adv = !out_valid | out_ready. This is one global stall: when adv=0 every stage holds, and there is no bubble collapsing.
- in_ready = adv. A transfer occurs on an edge where in_valid & in_ready. A stage-1 valid bit loads in_valid & adv, so a cycle with adv=1 and in_valid=0 inserts a bubble.
- Effective operand: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage s (1..NG) handles bits [s·GROUP−1 : (s−1)·GROUP]:
  - p_i = a_i ^ b_eff_i, g_i = a_i & b_eff_i.
  - Each carry inside the slice is the full lookahead sum-of-products of p, g and the slice carry-in. No ripple between bits is allowed.
  - sum_i = p_i ^ c_i.
- Stage s registers:
  - its slice of sum and the slice carry-out;
  - the untouched upper operand bits (a and b_eff, bits above the slice);
  - the accumulated lower sum bits;
  - the MSB operand signs needed for ovf;
  - a valid bit.
- Stage 1 takes c0 and the raw inputs. Stage s>1 takes the carry registered by stage s−1.
- Final stage outputs:
  - sum is the accumulated bits.
  - cout is the slice carry-out of stage NG.
  - ovf = (a[W−1] == b_eff[W−1]) & (sum[W−1] != a[W−1]).
  - zero = (sum == 0).
- Outputs are registered. sum, cout, ovf and zero are held stable while out_valid & !out_ready.
- Data registers may load on any advancing edge, including bubbles. Only the valid bits are qualified.

## Timing
- Reset (rst_n=0 at an edge): all stage valid bits cleared; sum, cout, ovf, zero = 0; out_valid = 0.
- in_ready is combinational from out_valid and out_ready, so in_ready = 1 during and after reset.
- Reset mid-operation discards every in-flight operation. No result is produced for inputs accepted before or on the reset edge.
- Latency: an input accepted at edge k appears with out_valid=1 after edge k+NG−1. That is NG cycles counting the accepting edge, e.g. 4 for 16/4, 1 for WIDTH=GROUP. Stall cycles add one-for-one.
- Throughput: one result per cycle while out_ready=1.
- Stall, then release: when out_ready rises, the held result transfers on that edge. A new input may be accepted on the same edge, and the pipeline shifts by one.
- Simultaneous accept and emit on one edge is legal and loses nothing.
- Boundary arithmetic: carry wraps modulo 2^WIDTH. sub with b=0 gives sum=a, cout=1.

## Test plan
- Reset/idle: hold rst_n=0 for 2 cycles. All outputs 0, out_valid=0, in_ready=1. Release with in_valid=0: out_valid stays 0.
- Latency, WIDTH=16, GROUP=4: a=0x1234, b=0x4321, cin=0, sub=0 accepted at edge 0. out_valid rises after edge 3 with sum=0x5555, cout=0, ovf=0, zero=0.
- Full carry chain: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1, cout=1.
- Back-pressure: stream 8 back-to-back adds i+i (i=1..8). Hold out_ready=0 for 5 cycles mid-stream. All 8 results (2,4,…,16) arrive in order with none dropped or duplicated. in_ready=0 exactly while out_valid & !out_ready.
- Reset mid-stream plus parameter sweep: assert rst_n=0 with 3 operations in flight. No out_valid follows for them. Repeat the random add/sub comparison against a behavioural a±b model for (WIDTH,GROUP) = (16,4), (32,8), (8,1), (12,3), 1000 vectors each.
